rc_osc_freq_meter: RTL

//  Downstream consumer of the 500 kHz RC oscillator macro: drives the oscillator enable and counts

---
 rtl/rc_osc_pkg.sv | 16 +
 rtl/rc_osc_sync_edge.sv | 31 +++
 rtl/rc_osc_freq_meter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rc_osc_pkg.sv
// Shared definitions for the RC oscillator frequency meter: FSM state
// encoding and default parameter values.
package rc_osc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned CNT_W_DEF         = 16;
  localparam int unsigned WIN_W_DEF         = 20;
  localparam int unsigned SETTLE_CYCLES_DEF = 1024;

endpackage

// File: rtl/rc_osc_sync_edge.sv
// Synchronizes the asynchronous oscillator output into clk and flags rising
// edges; a synchronous clear holds every flop at 0 while the oscillator is off.
module rc_osc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else if (clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rc_osc_freq_meter.sv
// Enables the RC oscillator, optionally lets it settle, then counts its rising
// edges over a programmable window of clk cycles and reports count/range flags.
module rc_osc_freq_meter
  import rc_osc_pkg::*;
#(
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned WIN_W         = WIN_W_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             keep_on,
  input  logic [WIN_W-1:0] win_cycles,
  input  logic [CNT_W-1:0] lo_thresh,
  input  logic [CNT_W-1:0] hi_thresh,
  input  logic             osc_dout,
  output logic             osc_ena,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             in_range
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [SET_W-1:0] scnt_q;
  logic [WIN_W-1:0] wcnt_q, win_q, win_eff;
  logic [CNT_W-1:0] lo_q, hi_q, lo_eff, hi_eff;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             ovf_q, ovf_d;
  logic             rise, accept, enter_meas, enter_done;

  rc_osc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (~osc_ena),
    .din  (osc_dout),
    .rise (rise)
  );

  // On the accepting cycle the captured copies are not loaded yet, so the
  // live inputs feed any same-cycle jump straight into MEASURE or DONE.
  always_comb begin
    accept  = (state_q == IDLE) && start;
    win_eff = accept ? win_cycles : win_q;
    lo_eff  = accept ? lo_thresh  : lo_q;
    hi_eff  = accept ? hi_thresh  : hi_q;

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (SETTLE_CYCLES == 0) state_d = (win_eff == '0) ? DONE : MEASURE;
          else                    state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (abort)                state_d = IDLE;
        else if (scnt_q == '0)    state_d = (win_q == '0) ? DONE : MEASURE;
      end
      MEASURE: begin
        if (abort)                state_d = IDLE;
        else if (wcnt_q == '0)    state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    enter_meas = (state_d == MEASURE) && (state_q != MEASURE);
    enter_done = (state_d == DONE) && (state_q != DONE);

    ecnt_d = ecnt_q;
    ovf_d  = ovf_q;
    if ((state_q == IDLE) || (state_q == SETTLE)) begin
      ecnt_d = '0;
      ovf_d  = 1'b0;
    end else if ((state_q == MEASURE) && rise) begin
      if (&ecnt_q) ovf_d  = 1'b1;
      else         ecnt_d = ecnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      scnt_q   <= '0;
      wcnt_q   <= '0;
      win_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      ecnt_q   <= '0;
      ovf_q    <= 1'b0;
      osc_ena  <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      in_range <= 1'b0;
    end else begin
      state_q <= state_d;
      ecnt_q  <= ecnt_d;
      ovf_q   <= ovf_d;

      if (accept) begin
        win_q  <= win_cycles;
        lo_q   <= lo_thresh;
        hi_q   <= hi_thresh;
        scnt_q <= SET_LOAD;
      end else if (state_q == SETTLE) begin
        scnt_q <= scnt_q - 1'b1;
      end

      if (enter_meas)              wcnt_q <= win_eff - 1'b1;
      else if (state_q == MEASURE) wcnt_q <= wcnt_q - 1'b1;

      if (accept)
        osc_ena <= 1'b1;
      else if (abort && ((state_q == SETTLE) || (state_q == MEASURE)))
        osc_ena <= 1'b0;
      else if ((state_q == DONE) && !keep_on)
        osc_ena <= 1'b0;

      done <= enter_done;
      if (enter_done) begin
        count    <= ecnt_d;
        overflow <= ovf_d;
        in_range <= !ovf_d && (lo_eff <= ecnt_d) && (ecnt_d <= hi_eff);
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
